// File: rtl/camera_pkg.sv
// Shared types and width helpers for the camera window reader.
package camera_pkg;
  typedef enum logic {WAIT_SYNC = 1'b0, ACTIVE = 1'b1} cam_state_e;

  function automatic int pix_w(input int data_w, input int pix_bytes);
    return data_w * pix_bytes;
  endfunction
endpackage

// File: rtl/camera_pixel_packer.sv
// Packs PIX_BYTES sensor beats into one pixel (first beat in MSBs) and tracks the column.
module camera_pixel_packer
  import camera_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PIX_BYTES = 1,
  parameter int COORD_W   = 16,
  localparam int PIX_W    = pix_w(DATA_W, PIX_BYTES)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [DATA_W-1:0]  i_data,
  input  logic               i_hs,
  input  logic               i_hs_fall,
  output logic               o_done,
  output logic [PIX_W-1:0]   o_pix,
  output logic [COORD_W-1:0] o_col
);
  logic [1:0]         r_phase;
  logic [PIX_W-1:0]   r_acc;
  logic [COORD_W-1:0] r_col;

  // Older beats shift out of the top, so the accumulator never needs clearing.
  assign o_done = i_hs && (r_phase == 2'(PIX_BYTES - 1));
  assign o_pix  = (r_acc << DATA_W) | PIX_W'(i_data);
  assign o_col  = r_col;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= '0;
      r_acc   <= '0;
      r_col   <= '0;
    end else if (i_hs_fall) begin
      r_phase <= '0;
      r_col   <= '0;
    end else if (i_hs) begin
      r_acc <= o_pix;
      if (o_done) begin
        r_phase <= '0;
        r_col   <= r_col + COORD_W'(1);
      end else begin
        r_phase <= r_phase + 2'd1;
      end
    end
  end
endmodule

// File: rtl/camera_window_reader.sv
// Crops and decimates a window out of a DVP-style camera stream, with frame and line checks.
module camera_window_reader
  import camera_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PIX_BYTES = 1,
  parameter int COORD_W   = 16,
  localparam int PIX_W    = pix_w(DATA_W, PIX_BYTES)
) (
  input  logic               pixclk_i,
  input  logic               rst_n_i,
  input  logic [DATA_W-1:0]  pixel_data_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  input  logic [COORD_W-1:0] win_x0_i,
  input  logic [COORD_W-1:0] win_y0_i,
  input  logic [COORD_W-1:0] win_w_i,
  input  logic [COORD_W-1:0] win_h_i,
  input  logic [1:0]         dec_log2_i,
  input  logic               err_clr_i,
  output logic               pix_valid_o,
  output logic [PIX_W-1:0]   pix_o,
  output logic [COORD_W-1:0] row_o,
  output logic [COORD_W-1:0] col_o,
  output logic               sof_o,
  output logic               eol_o,
  output logic               eof_o,
  output logic [15:0]        frame_cnt_o,
  output logic               line_err_o,
  output logic               fifo_rst_o
);
  cam_state_e         r_state;
  logic [DATA_W-1:0]  r_data;
  logic               r_hs, r_vs, r_hs_d, r_vs_d;
  logic [COORD_W-1:0] r_x0, r_y0, r_w, r_h;
  logic [1:0]         r_dec;
  logic [COORD_W-1:0] r_line;
  logic [COORD_W+1:0] r_beats, r_ref_beats;
  logic               r_ref_vld;

  logic               w_vs_fall, w_hs_fall, w_done;
  logic [PIX_W-1:0]   w_pix;
  logic [COORD_W-1:0] w_col, w_dx, w_dy, w_mask, w_xlast, w_ylast;
  logic               w_in_x, w_in_y, w_dec_ok, w_emit, w_eol, w_eof, w_sof;
  logic               w_line_end, w_err_set;

  assign w_vs_fall = r_vs_d & ~r_vs;
  assign w_hs_fall = r_hs_d & ~r_hs;

  camera_pixel_packer #(
    .DATA_W(DATA_W), .PIX_BYTES(PIX_BYTES), .COORD_W(COORD_W)
  ) u_packer (
    .i_clk(pixclk_i), .i_rst_n(rst_n_i), .i_data(r_data), .i_hs(r_hs),
    .i_hs_fall(w_hs_fall), .o_done(w_done), .o_pix(w_pix), .o_col(w_col)
  );

  // Extended-width upper bounds so x0+w / y0+h near the top of the range cannot wrap.
  assign w_in_x = (w_col >= r_x0) &&
                  ({1'b0, w_col} < ({1'b0, r_x0} + {1'b0, r_w}));
  assign w_in_y = (r_line >= r_y0) &&
                  ({1'b0, r_line} < ({1'b0, r_y0} + {1'b0, r_h}));
  assign w_dx     = w_col - r_x0;
  assign w_dy     = r_line - r_y0;
  assign w_mask   = ~({COORD_W{1'b1}} << r_dec);
  assign w_dec_ok = ((w_dx & w_mask) == '0) && ((w_dy & w_mask) == '0);
  assign w_xlast  = (r_w - COORD_W'(1)) & ~w_mask;
  assign w_ylast  = (r_h - COORD_W'(1)) & ~w_mask;
  assign w_emit   = (r_state == ACTIVE) && w_done && w_in_x && w_in_y && w_dec_ok;
  assign w_sof    = (w_dx == '0) && (w_dy == '0);
  assign w_eol    = (w_dx == w_xlast);
  assign w_eof    = w_eol && (w_dy == w_ylast);

  // A line closing in the same cycle as vsync falls belongs to the old frame; skip it.
  assign w_line_end = (r_state == ACTIVE) && w_hs_fall && !w_vs_fall;
  assign w_err_set  = w_line_end && r_ref_vld && (r_beats != r_ref_beats);

  always_ff @(posedge pixclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= WAIT_SYNC;
      r_data      <= '0;
      r_hs        <= 1'b0;
      r_vs        <= 1'b0;
      r_hs_d      <= 1'b0;
      r_vs_d      <= 1'b0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_dec       <= '0;
      r_line      <= '0;
      r_beats     <= '0;
      r_ref_beats <= '0;
      r_ref_vld   <= 1'b0;
      pix_valid_o <= 1'b0;
      pix_o       <= '0;
      row_o       <= '0;
      col_o       <= '0;
      sof_o       <= 1'b0;
      eol_o       <= 1'b0;
      eof_o       <= 1'b0;
      frame_cnt_o <= '0;
      line_err_o  <= 1'b0;
      fifo_rst_o  <= 1'b1;
    end else begin
      r_data <= pixel_data_i;
      r_hs   <= hsync_i;
      r_vs   <= vsync_i;
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;

      pix_valid_o <= w_emit;
      sof_o       <= w_emit & w_sof;
      eol_o       <= w_emit & w_eol;
      eof_o       <= w_emit & w_eof;
      if (w_emit) begin
        pix_o <= w_pix;
        col_o <= w_dx >> r_dec;
        row_o <= w_dy >> r_dec;
      end

      if (w_vs_fall) begin
        r_x0       <= win_x0_i;
        r_y0       <= win_y0_i;
        r_w        <= win_w_i;
        r_h        <= win_h_i;
        r_dec      <= dec_log2_i;
        r_line     <= '0;
        r_ref_vld  <= 1'b0;
        r_state    <= ACTIVE;
        fifo_rst_o <= 1'b0;
        if (r_state == ACTIVE) frame_cnt_o <= frame_cnt_o + 16'd1;
      end else if (w_hs_fall) begin
        r_line <= r_line + COORD_W'(1);
      end

      if (w_hs_fall)  r_beats <= '0;
      else if (r_hs)  r_beats <= r_beats + (COORD_W+2)'(1);

      if (w_line_end && !r_ref_vld) begin
        r_ref_beats <= r_beats;
        r_ref_vld   <= 1'b1;
      end

      if (w_err_set)      line_err_o <= 1'b1;
      else if (err_clr_i) line_err_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_camera_window_reader.sv
// Randomized frame stimulus with a queue scoreboard fed by a frame-level reference model.
module tb_camera_window_reader;
  localparam int DW = 8, PB = 2, CW = 16, PW = DW * PB;

  logic          pixclk_i = 1'b0;
  logic          rst_n_i  = 1'b0;
  logic [DW-1:0] pixel_data_i = '0;
  logic          hsync_i = 1'b0, vsync_i = 1'b0;
  logic [CW-1:0] win_x0_i = '0, win_y0_i = '0, win_w_i = '0, win_h_i = '0;
  logic [1:0]    dec_log2_i = '0;
  logic          err_clr_i = 1'b0;
  logic          pix_valid_o, sof_o, eol_o, eof_o, line_err_o, fifo_rst_o;
  logic [PW-1:0] pix_o;
  logic [CW-1:0] row_o, col_o;
  logic [15:0]   frame_cnt_o;

  camera_window_reader #(.DATA_W(DW), .PIX_BYTES(PB), .COORD_W(CW)) dut (
    .pixclk_i(pixclk_i), .rst_n_i(rst_n_i), .pixel_data_i(pixel_data_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .win_x0_i(win_x0_i), .win_y0_i(win_y0_i),
    .win_w_i(win_w_i), .win_h_i(win_h_i), .dec_log2_i(dec_log2_i), .err_clr_i(err_clr_i),
    .pix_valid_o(pix_valid_o), .pix_o(pix_o), .row_o(row_o), .col_o(col_o),
    .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o), .frame_cnt_o(frame_cnt_o),
    .line_err_o(line_err_o), .fifo_rst_o(fifo_rst_o)
  );

  always #5 pixclk_i = ~pixclk_i;

  int cyc = 0;
  always @(posedge pixclk_i) cyc <= cyc + 1;

  typedef struct {
    logic [PW-1:0] pix;
    int row, col;
    bit sof, eol, eof;
  } exp_t;

  exp_t sbq[$];
  int   tq[$];
  int   n_chk = 0, n_pass = 0;
  logic [7:0] fb [0:31][0:63];
  int   cx0, cy0, cw, ch, cdec;
  bit   m_active = 0, exp_err = 0, force_abcd = 0;
  int   exp_fc = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge pixclk_i);
    #1;
  endtask

  // Pixel (L,c) of the current frame lands in the decimated window.
  function automatic bit emits(input int L, input int c);
    int d;
    d = 1 << cdec;
    return (L >= cy0) && (L < cy0 + ch) && (c >= cx0) && (c < cx0 + cw) &&
           ((c - cx0) % d == 0) && ((L - cy0) % d == 0);
  endfunction

  task automatic model_frame(input int npx, input int nl, input int short_l);
    exp_t tmp[$];
    int   tl[$];
    exp_t e;
    int   np;
    for (int L = 0; L < nl; L++) begin
      np = (2 * npx - ((L == short_l) ? 1 : 0)) / PB;
      for (int c = 0; c < np; c++) begin
        if (emits(L, c)) begin
          e.pix = {fb[L][2*c], fb[L][2*c+1]};
          e.row = (L - cy0) / (1 << cdec);
          e.col = (c - cx0) / (1 << cdec);
          e.sof = 0; e.eol = 0; e.eof = 0;
          tmp.push_back(e);
          tl.push_back(L);
        end
      end
    end
    for (int i = 0; i < tmp.size(); i++) begin
      tmp[i].sof = (i == 0);
      tmp[i].eof = (i == tmp.size() - 1);
      tmp[i].eol = (i == tmp.size() - 1) || (tl[i+1] != tl[i]);
      sbq.push_back(tmp[i]);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_flags"}, {pix_valid_o, sof_o, eol_o, eof_o, line_err_o, fifo_rst_o, frame_cnt_o},
        {5'b0, 1'b1, 16'h0});
    chk({name, "_data"}, {pix_o, row_o, col_o}, 48'h0);
  endtask

  task automatic drive_frame(input int npx, input int nl, input int x0, input int y0,
                             input int w, input int h, input int dec,
                             input int short_l, input int new_w, input int rst_l);
    bit aborted;
    int nb;
    aborted = 0;
    for (int L = 0; L < 32; L++)
      for (int b = 0; b < 64; b++) fb[L][b] = 8'($urandom);
    if (force_abcd) begin
      fb[0][0] = 8'hAB;
      fb[0][1] = 8'hCD;
    end
    win_x0_i = CW'(x0); win_y0_i = CW'(y0); win_w_i = CW'(w); win_h_i = CW'(h);
    dec_log2_i = 2'(dec);
    vsync_i = 1'b1; hsync_i = 1'b0;
    repeat (3) tick();
    cx0 = x0; cy0 = y0; cw = w; ch = h; cdec = dec;
    if (m_active) exp_fc = (exp_fc + 1) & 16'hFFFF;
    m_active = 1;
    if (short_l > 0 && short_l < nl) exp_err = 1;
    model_frame(npx, nl, short_l);
    vsync_i = 1'b0;
    tick(); tick();
    for (int L = 0; L < nl; L++) begin
      hsync_i = 1'b1;
      nb = 2 * npx - ((L == short_l) ? 1 : 0);
      for (int b = 0; b < nb; b++) begin
        pixel_data_i = fb[L][b];
        if (L == 1 && b == 0 && new_w >= 0) win_w_i = CW'(new_w);
        if (L == rst_l && b == 3 && !aborted) begin
          rst_n_i = 1'b0;
          #1;
          check_reset_outputs("midline_reset");
          sbq.delete(); tq.delete();
          m_active = 0; exp_fc = 0; exp_err = 0; aborted = 1;
          tick();
          rst_n_i = 1'b1;
        end
        if (!aborted && (b % 2 == 1) && emits(L, b / 2)) tq.push_back(cyc + 2);
        tick();
      end
      hsync_i = 1'b0;
      tick();
      if ($urandom_range(0, 1) == 1) tick();
    end
    repeat (4) tick();
    chk("frame_status", {fifo_rst_o, line_err_o, frame_cnt_o},
        {~m_active, exp_err, 16'(exp_fc)});
  endtask

  // Monitor: every presented pixel must match the head of the scoreboard.
  exp_t mon_e;
  int   mon_t;
  always @(negedge pixclk_i) begin
    if (pix_valid_o) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pixel got pix=%h row=%0d col=%0d exp=none", pix_o, row_o, col_o);
      end else begin
        mon_e = sbq.pop_front();
        chk("pixel", {pix_o, row_o, col_o, sof_o, eol_o, eof_o},
            {mon_e.pix, 16'(mon_e.row), 16'(mon_e.col), mon_e.sof, mon_e.eol, mon_e.eof});
        mon_t = (tq.size() > 0) ? tq.pop_front() : -1;
        chk("latency_cycle", 64'(cyc), 64'(mon_t));
      end
    end
  end

  initial begin
    int npx, nl, x0, y0, w, h;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n_i = 1'b1;
    tick();

    force_abcd = 1;
    drive_frame(4, 3, 0, 0, 1, 1, 0, -1, -1, -1);
    force_abcd = 0;
    drive_frame(10, 6, 0, 0, 8, 4, 1, -1, -1, -1);
    drive_frame(24, 22, 2, 2, 20, 18, 0, -1, -1, -1);
    drive_frame(8, 4, 1, 1, 0, 3, 0, -1, -1, -1);
    drive_frame(8, 4, 1, 1, 5, 0, 0, -1, -1, -1);
    drive_frame(12, 5, 2, 1, 4, 3, 0, -1, 6, -1);
    drive_frame(12, 5, 2, 1, 6, 3, 0, -1, -1, -1);

    drive_frame(8, 5, 1, 0, 5, 5, 0, 2, -1, -1);
    repeat (5) tick();
    chk("err_held", 64'(line_err_o), 64'd1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    exp_err = 0;
    tick();
    chk("err_clr", 64'(line_err_o), 64'd0);

    drive_frame(8, 5, 1, 0, 5, 5, 1, 3, -1, -1);
    drive_frame(8, 4, 0, 0, 8, 4, 0, -1, -1, 1);
    drive_frame(9, 4, 1, 1, 7, 3, 0, -1, -1, -1);

    for (int f = 0; f < 20; f++) begin
      npx = $urandom_range(2, 24);
      nl  = $urandom_range(2, 20);
      x0  = $urandom_range(0, npx - 1);
      w   = $urandom_range(0, npx - x0);
      y0  = $urandom_range(0, nl - 1);
      h   = $urandom_range(0, nl - y0);
      drive_frame(npx, nl, x0, y0, w, h, $urandom_range(0, 3), -1, -1, -1);
    end

    repeat (10) tick();
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    chk("timestamps_drained", 64'(tq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
